fpu_div_arbiter: RTL

Round-robin scheduler that shares one `fpu_div` instance between `NUM_REQ` requesters. It sits between the requester ports (issue units, test harness lanes) and the divider. It captures one operand pair at a time, pulses the divider's `valid`, waits for its one-cycle `ready`, and returns the quotient to the requester that issued it. An optional watchdog aborts a hung divide and forces a divider reset.

---
 rtl/fpu_div_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/fpu_div_arbiter.sv
`default_nettype none
// ============================================================================
// fpu_div_arbiter: round-robin scheduler sharing one fpu_div across NUM_REQ
// requesters. Optional hung-divide watchdog: define DIV_TIMEOUT_EN.  Rev 1.0
// ============================================================================
module fpu_div_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ),
  parameter int TIMEOUT = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_din1,
  input  logic [32*NUM_REQ-1:0] req_din2,
  output logic [NUM_REQ-1:0]    req_grant,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_result,
  output logic                  rsp_error,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           div_din1,
  output logic [31:0]           div_din2,
  output logic                  div_valid,
  input  logic [31:0]           div_result,
  input  logic                  div_ready,
  output logic                  div_rst,
  output logic [15:0]           ops_done
);

  localparam logic [IDW:0]         c_NUM  = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0]       c_LAST = IDW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]   c_ONE  = NUM_REQ'(1);
  localparam logic [31:0]          c_QNAN = 32'h7FC0_0000;

  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (TIMEOUT < 1)) begin : g_param_check
    $error("fpu_div_arbiter: illegal NUM_REQ or TIMEOUT");
  end

`ifdef DIV_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ISSUE = 3'd1, S_BUSY = 3'd2, S_ABORT = 3'd3, S_RESP = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ISSUE = 3'd1, S_BUSY = 3'd2, S_RESP = 3'd4
  } state_t;
`endif

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [31:0]    din1_q, din1_d;
  logic [31:0]    din2_q, din2_d;
  logic [31:0]    result_q, result_d;
  logic [15:0]    ops_q, ops_d;

`ifdef DIV_TIMEOUT_EN
  localparam int            TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] c_TLAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          abt_q, abt_d;
  logic          err_q, err_d;
`endif

  // First requester at or after rr_ptr, with wrap: scan downward so the
  // smallest offset is the last one written.
  logic           any_req;
  logic [IDW-1:0] win;
  logic [IDW:0]   idx_w;
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    idx_w   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_w = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (idx_w >= c_NUM) idx_w = idx_w - c_NUM;
      if (req_valid[idx_w[IDW-1:0]]) begin
        any_req = 1'b1;
        win     = idx_w[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    din1_d   = din1_q;
    din2_d   = din2_q;
    result_d = result_q;
    ops_d    = ops_q;
`ifdef DIV_TIMEOUT_EN
    timer_d  = timer_q;
    abt_d    = abt_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          din1_d   = req_din1[{win, 5'd0} +: 32];
          din2_d   = req_din2[{win, 5'd0} +: 32];
          owner_d  = win;
          rr_ptr_d = (win == c_LAST) ? '0 : win + 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef DIV_TIMEOUT_EN
        timer_d = '0;
`endif
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (div_ready) begin
          result_d = div_result;
`ifdef DIV_TIMEOUT_EN
          err_d    = 1'b0;
`endif
          state_d  = S_RESP;
        end
`ifdef DIV_TIMEOUT_EN
        else if (timer_q == c_TLAST) begin
          abt_d   = 1'b0;
          state_d = S_ABORT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
`ifdef DIV_TIMEOUT_EN
      // Two cycles of divider reset, then report a quiet NaN with error set.
      S_ABORT: begin
        if (abt_q) begin
          result_d = c_QNAN;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end else begin
          abt_d = 1'b1;
        end
      end
`endif
      S_RESP: begin
        ops_d   = ops_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      din1_q   <= '0;
      din2_q   <= '0;
      result_q <= '0;
      ops_q    <= '0;
`ifdef DIV_TIMEOUT_EN
      timer_q  <= '0;
      abt_q    <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      din1_q   <= din1_d;
      din2_q   <= din2_d;
      result_q <= result_d;
      ops_q    <= ops_d;
`ifdef DIV_TIMEOUT_EN
      timer_q  <= timer_d;
      abt_q    <= abt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign req_grant  = (state_q == S_ISSUE) ? (c_ONE << owner_q) : '0;
  assign div_valid  = (state_q == S_ISSUE);
  assign rsp_valid  = (state_q == S_RESP) ? (c_ONE << owner_q) : '0;
  assign rsp_id     = (state_q == S_RESP) ? owner_q : '0;
  assign rsp_result = result_q;
  assign div_din1   = din1_q;
  assign div_din2   = din2_q;
  assign ops_done   = ops_q;
`ifdef DIV_TIMEOUT_EN
  assign rsp_error  = err_q;
  assign div_rst    = (state_q == S_ABORT);
`else
  assign rsp_error  = 1'b0;
  assign div_rst    = 1'b0;
`endif

endmodule
`default_nettype wire
